// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential barrel shifter: default sizes,
// operation encodings and controller state encoding.
package shifter_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AMT_W_DEF = 4;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One log2 stage of a barrel shifter: a single row of 2:1 muxes choosing
// between the operand and its 2^k-shifted candidate.
module mux_2_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF,
    parameter int K_W   = (AMT_W > 1) ? $clog2(AMT_W) : 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic [K_W-1:0]   k,
    input  logic             enable,
    output logic [WIDTH-1:0] result
);

    logic [AMT_W:0]     shamt;
    logic [WIDTH-1:0]   cand;

    assign shamt = (AMT_W + 1)'(1) << k;

    // SRA fills with the current MSB, which always equals the original sign.
    always_comb begin
        cand = data;
        case (op)
            OP_SLL:  cand = data << shamt;
            OP_SRL:  cand = data >> shamt;
            OP_SRA:  cand = WIDTH'($signed(data) >>> shamt);
            OP_ROR:  cand = (data >> shamt) | (data << (WIDTH - int'(shamt)));
            default: cand = data;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_2_1 u_mux (
            .a   (data[i]),
            .b   (cand[i]),
            .sel (enable),
            .y   (result[i])
        );
    end

endmodule

// File: rtl/barrel_shift_ctrl.sv
// Sequential 16-bit barrel shifter controller: applies one log2 stage per
// clock through a single shared shift_stage row.
module barrel_shift_ctrl
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int K_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(AMT_W - 1);

    state_t           state;
    state_t           state_nx;
    logic [K_W-1:0]   k;
    logic [WIDTH-1:0] data_r;
    logic [AMT_W-1:0] amt_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] stage_out;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready and ready on neither.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = result_r;

    shift_stage #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W),
        .K_W   (K_W)
    ) u_stage (
        .data   (data_r),
        .op     (op_r),
        .k      (k),
        .enable (amt_r[k]),
        .result (stage_out)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = SHIFT;
            SHIFT:   if (k == K_LAST) state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            data_r   <= '0;
            amt_r    <= '0;
            op_r     <= '0;
            result_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r <= in_data;
                        amt_r  <= in_amt;
                        op_r   <= in_op;
                        k      <= '0;
                    end
                end
                SHIFT: begin
                    data_r <= stage_out;
                    // result_r only changes on the final stage so out_data
                    // keeps its last value while the next operand is shifting.
                    if (k == K_LAST) begin
                        result_r <= stage_out;
                        k        <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// Directed and table-driven bench for barrel_shift_ctrl: vectors, latency,
// backpressure, mid-operation reset and back-to-back throughput.
module tb_barrel_shift_ctrl;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  amt;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];
    logic [15:0] exp_q[$];

    barrel_shift_ctrl #(.WIDTH(16), .AMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a,
                                              input logic [1:0] o);
        logic [15:0] r;
        case (o)
            OP_SLL:  r = d << a;
            OP_SRL:  r = d >> a;
            OP_SRA:  r = 16'($signed(d) >>> a);
            default: r = (d >> a) | (d << (16 - int'(a)));
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE at a sample point; returns when out_valid is seen.
    task automatic run_req(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o,
                           output logic [15:0] res, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = o;
        tick();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = out_data;
    endtask

    initial begin
        logic [15:0] res;
        int lat;
        int cyc, last_acc, n_acc, n_out;
        logic need_new;

        vecs[0]  = '{16'h0001, 4'd15, OP_SLL, 16'h8000};
        vecs[1]  = '{16'h8000, 4'd4,  OP_SRA, 16'hF800};
        vecs[2]  = '{16'hF00F, 4'd8,  OP_SRL, 16'h00F0};
        vecs[3]  = '{16'h1234, 4'd4,  OP_ROR, 16'h4123};
        vecs[4]  = '{16'hA5A5, 4'd0,  OP_SRA, 16'hA5A5};
        vecs[5]  = '{16'h7FF0, 4'd4,  OP_SRA, 16'h07FF};
        vecs[6]  = '{16'h0001, 4'd1,  OP_ROR, 16'h8000};
        vecs[7]  = '{16'h8000, 4'd15, OP_SRL, 16'h0001};
        vecs[8]  = '{16'h8001, 4'd15, OP_SRA, 16'hFFFF};
        vecs[9]  = '{16'hABCD, 4'd15, OP_ROR, 16'h579B};
        vecs[10] = '{16'hF0F0, 4'd3,  OP_SLL, 16'h8780};
        vecs[11] = '{16'hC3C3, 4'd0,  OP_ROR, 16'hC3C3};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].data, vecs[i].amt, vecs[i].op, res, lat);
            chk($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_busy", i), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("vec%0d_handoff_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("vec%0d_handoff_valid", i), 32'(out_valid), 32'd0);
        end

        // Backpressure in DONE, with an in_valid pulse that must be ignored.
        out_ready = 1'b0;
        run_req(16'h1234, 4'd4, OP_ROR, res, lat);
        chk("bp_data", 32'(res), 32'h4123);
        for (int c = 0; c < 3; c++) begin
            in_valid = (c == 1);
            in_data  = 16'hFFFF;
            in_amt   = 4'd1;
            in_op    = OP_SLL;
            tick();
            chk($sformatf("bp_hold_data%0d", c), 32'(out_data), 32'h4123);
            chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_ready%0d", c), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_hold", 32'(out_data), 32'h4123);

        // Reset on the edge after acceptance.
        in_valid = 1'b1; in_data = 16'h5555; in_amt = 4'd3; in_op = OP_SLL;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        run_req(16'h00FF, 4'd8, OP_SLL, res, lat);
        chk("midrst_next_data", 32'(res), 32'hFF00);
        chk("midrst_next_latency", 32'(lat), 32'd4);
        tick();

        // Back-to-back with in_valid held high; accepts every 6 cycles.
        out_ready = 1'b1;
        in_data = 16'($urandom); in_amt = 4'($urandom_range(0, 15)); in_op = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
        cyc = 0; last_acc = 0; n_acc = 0; n_out = 0;
        while (n_out < 8 && cyc < 200) begin
            need_new = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("b2b_unexpected_out", 32'(out_data), 32'hDEAD);
                else chk($sformatf("b2b_data%0d", n_out), 32'(out_data), 32'(exp_q.pop_front()));
                n_out++;
            end
            if (in_ready && in_valid) begin
                exp_q.push_back(ref_shift(in_data, in_amt, in_op));
                if (n_acc > 0) chk($sformatf("b2b_spacing%0d", n_acc), 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                n_acc++;
                need_new = 1'b1;
            end
            tick();
            cyc++;
            if (need_new) begin
                in_valid = (n_acc < 8);
                in_data  = 16'($urandom);
                in_amt   = 4'($urandom_range(0, 15));
                in_op    = 2'($urandom_range(0, 3));
            end
        end
        in_valid = 1'b0;
        chk("b2b_results", 32'(n_out), 32'd8);
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
